// File: rtl/nes_pad_sequencer.sv
// nes_pad_sequencer: NES gamepad latch/clock sequencer with a synchronised serial capture per poll period.
// Define NES_PAD_EDGE_EN to add pressed_o, the buttons newly pressed since the previous frame.
module nes_pad_sequencer #(
    parameter int POLL_DIV   = 666666,
    parameter int LATCH_CYC  = 480,
    parameter int PULSE_HALF = 240
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       poll_en_i,
    input  logic       pad_data_ni,
    output logic       latch_o,
    output logic       pulse_o,
    output logic       poll_tick_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       busy_o
`ifdef NES_PAD_EDGE_EN
    ,
    output logic [7:0] pressed_o
`endif
);
    localparam int MAX_CYC = (LATCH_CYC > PULSE_HALF) ? LATCH_CYC : PULSE_HALF;
    localparam int PH_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PC_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);
    localparam logic [PH_W-1:0] HALF_LAST = PH_W'(PULSE_HALF - 1);
    localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_DIV - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LATCH_LO, PULSE_HI, PULSE_LO, DONE} state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q;
    logic [PC_W-1:0] poll_cnt_q;
    logic [2:0]      idx_q;
    logic [6:0]      shift_q;
    logic [1:0]      sync_q;
    logic            latch_q, pulse_q, valid_q;
    logic [7:0]      buttons_q;
    logic            tick, sample;
    logic [7:0]      new_buttons;

    assign tick        = poll_cnt_q == POLL_LAST;
    assign sample      = (state_q == LATCH_LO || state_q == PULSE_LO) && phase_q == HALF_LAST;
    assign new_buttons = ~{sync_q[1], shift_q};

    // Two-flop synchroniser for the asynchronous pad data, idling at released (1)
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], pad_data_ni};
    end

    // Free-running poll period counter, independent of the frame sequencer
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) poll_cnt_q <= '0;
        else poll_cnt_q <= tick ? '0 : poll_cnt_q + 1'b1;
    end

    // Next-state decode; ticks outside IDLE are simply ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (tick && poll_en_i) state_d = LATCH;
            LATCH:    if (phase_q == LATCH_LAST) state_d = LATCH_LO;
            LATCH_LO: if (phase_q == HALF_LAST) state_d = PULSE_HI;
            PULSE_HI: if (phase_q == HALF_LAST) state_d = PULSE_LO;
            PULSE_LO: if (phase_q == HALF_LAST) state_d = (idx_q == 3'd7) ? DONE : PULSE_HI;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Frame sequencer: phase timing, serial capture and outputs registered from the next state
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= (state_d != state_q || state_q == IDLE) ? '0 : phase_q + 1'b1;
            latch_q <= state_d == LATCH;
            pulse_q <= state_d == PULSE_HI;
            valid_q <= state_d == DONE;
            if (sample) begin
                shift_q <= {sync_q[1], shift_q[6:1]};
                idx_q   <= idx_q + 1'b1;
            end
            if (state_d == DONE) buttons_q <= new_buttons;
        end
    end

`ifdef NES_PAD_EDGE_EN
    logic [7:0] pressed_q;

    // Newly pressed buttons, presented only alongside valid
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) pressed_q <= '0;
        else pressed_q <= (state_d == DONE) ? new_buttons & ~buttons_q : '0;
    end

    assign pressed_o = pressed_q;
`endif

    assign latch_o     = latch_q;
    assign pulse_o     = pulse_q;
    assign valid_o     = valid_q;
    assign buttons_o   = buttons_q;
    assign poll_tick_o = tick;
    assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_nes_pad_sequencer.sv
// tb_nes_pad_sequencer: randomized frame checks of nes_pad_sequencer against a frame-timing formula model.
module tb_nes_pad_sequencer;
    localparam int POLL_DIV   = 2000;
    localparam int LATCH_CYC  = 8;
    localparam int PULSE_HALF = 4;
    localparam int VALID_D    = LATCH_CYC + 15 * PULSE_HALF + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       poll_en = 1'b0;
    logic       pad_data_n;
    logic       latch, pulse, poll_tick, valid, busy;
    logic [7:0] buttons;
`ifdef NES_PAD_EDGE_EN
    logic [7:0] pressed;
`endif
    logic [7:0] pad_n = 8'hFF;
    logic [7:0] pad_sr = 8'hFF;
    logic       pulse_d = 1'b0;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fs = -1;
    logic [7:0] frame_btn = 8'h00;
    logic [7:0] m_buttons = 8'h00;
    logic [7:0] m_pressed = 8'h00;

    always #5 clk = ~clk;

    nes_pad_sequencer #(.POLL_DIV(POLL_DIV), .LATCH_CYC(LATCH_CYC), .PULSE_HALF(PULSE_HALF)) dut (
        .clk_i(clk),
        .reset_ni(rst_n),
        .poll_en_i(poll_en),
        .pad_data_ni(pad_data_n),
        .latch_o(latch),
        .pulse_o(pulse),
        .poll_tick_o(poll_tick),
        .buttons_o(buttons),
        .valid_o(valid),
        .busy_o(busy)
`ifdef NES_PAD_EDGE_EN
        ,
        .pressed_o(pressed)
`endif
    );

    // Pad model: parallel load while latched, shift one bit out per pad clock rising edge
    always @(posedge clk) begin
        pulse_d <= pulse;
        if (latch) pad_sr <= pad_n;
        else if (pulse && !pulse_d) pad_sr <= {1'b1, pad_sr[7:1]};
    end
    assign pad_data_n = pad_sr[0];

    function automatic int fd();
        return (fs < 0) ? -1 : cyc - fs;
    endfunction

    // Expected {poll_tick, latch, pulse, valid, busy} from the frame timing rules
    function automatic logic [4:0] model_vec();
        int d;
        int e;
        d = fd();
        e = d - (LATCH_CYC + PULSE_HALF + 1);
        return {(cyc % POLL_DIV) == POLL_DIV - 1,
                d >= 1 && d <= LATCH_CYC,
                e >= 0 && e < 14 * PULSE_HALF && (e % (2 * PULSE_HALF)) < PULSE_HALF,
                d == VALID_D,
                d >= 1 && d <= VALID_D};
    endfunction

    task automatic step();
        int d;
        d = fd();
        if (cyc % POLL_DIV == POLL_DIV - 1 && poll_en && !(d >= 1 && d <= VALID_D)) begin
            fs = cyc;
            frame_btn = ~pad_n;
        end
        @(posedge clk);
        cyc++;
        m_pressed = 8'h00;
        if (fd() == VALID_D) begin
            m_pressed = frame_btn & ~m_buttons;
            m_buttons = frame_btn;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        fs = -1;
        m_buttons = 8'h00;
        m_pressed = 8'h00;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({latch, pulse, poll_tick, valid, busy, buttons} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_held: got %b want 0", {latch, pulse, poll_tick, valid, busy, buttons});
        end
        @(negedge clk);
        do_reset();
        n_vec++;
        if ({latch, pulse, poll_tick, valid, busy, buttons} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_release: got %b want 0", {latch, pulse, poll_tick, valid, busy, buttons});
        end
    endtask

    task automatic test_frame_timing();
        int   latch_rises, pulse_rises, busy_cyc, overlap, valid_at;
        logic latch_p, pulse_p;
        latch_rises = 0; pulse_rises = 0; busy_cyc = 0; overlap = 0; valid_at = -1;
        latch_p = 1'b0; pulse_p = 1'b0;
        pad_n = 8'hFF;
        poll_en = 1'b1;
        for (int i = 0; i < 2080; i++) begin
            n_vec++;
            if ({poll_tick, latch, pulse, valid, busy} !== model_vec()) begin
                n_err++;
                $display("FAIL timing cycle %0d: got %b want %b", cyc, {poll_tick, latch, pulse, valid, busy}, model_vec());
            end
            if (latch && !latch_p) latch_rises++;
            if (pulse && !pulse_p) pulse_rises++;
            if (latch && pulse) overlap++;
            if (busy) busy_cyc++;
            if (valid) begin
                valid_at = cyc;
                n_vec++;
                if (buttons !== 8'h00) begin
                    n_err++;
                    $display("FAIL idle_buttons: got %h want 00", buttons);
                end
            end
            latch_p = latch;
            pulse_p = pulse;
            step();
        end
        n_vec++;
        if (latch_rises != 1) begin n_err++; $display("FAIL latch_count: got %0d want 1", latch_rises); end
        n_vec++;
        if (pulse_rises != 7) begin n_err++; $display("FAIL pulse_count: got %0d want 7", pulse_rises); end
        n_vec++;
        if (overlap != 0) begin n_err++; $display("FAIL latch_pulse_overlap: got %0d want 0", overlap); end
        n_vec++;
        if (busy_cyc != 69) begin n_err++; $display("FAIL busy_len: got %0d want 69", busy_cyc); end
        n_vec++;
        if (valid_at != 2068) begin n_err++; $display("FAIL valid_cycle: got %0d want 2068", valid_at); end
    endtask

    task automatic test_pattern();
        bit seen;
        pad_n = 8'hF6;
        wait_valid(2100, seen);
        n_vec++;
        if (!seen || buttons !== 8'h09) begin
            n_err++;
            $display("FAIL pattern_a_start: got %h (valid seen %0d) want 09", buttons, seen);
        end
        pad_n = 8'hFF;
        wait_valid(2100, seen);
        n_vec++;
        if (!seen || buttons !== 8'h00) begin
            n_err++;
            $display("FAIL pattern_released: got %h (valid seen %0d) want 00", buttons, seen);
        end
    endtask

    task automatic test_random();
        bit seen;
        for (int f = 0; f < 5; f++) begin
            seen = 1'b0;
            pad_n = 8'($urandom);
            for (int i = 0; i < 2100 && !seen; i++) begin
                step();
                n_vec++;
                if ({poll_tick, latch, pulse, valid, busy} !== model_vec()) begin
                    n_err++;
                    $display("FAIL random_timing cycle %0d: got %b want %b", cyc, {poll_tick, latch, pulse, valid, busy}, model_vec());
                end
                if (valid) begin
                    seen = 1'b1;
                    n_vec++;
                    if (buttons !== m_buttons) begin
                        n_err++;
                        $display("FAIL random_buttons frame %0d: got %h want %h", f, buttons, m_buttons);
                    end
                end
            end
            if (!seen) begin
                n_vec++;
                n_err++;
                $display("FAIL random_timeout frame %0d: got no valid want valid", f);
            end
        end
    endtask

    task automatic test_poll_disable();
        int         ticks;
        bit         seen;
        logic [7:0] hold;
        ticks = 0;
        hold = m_buttons;
        poll_en = 1'b0;
        pad_n = 8'h00;
        for (int i = 0; i < 6000; i++) begin
            step();
            n_vec++;
            if (latch || valid || busy || buttons !== hold) begin
                n_err++;
                $display("FAIL poll_off cycle %0d: got latch=%b valid=%b busy=%b buttons=%h want 0/0/0/%h", cyc, latch, valid, busy, buttons, hold);
            end
            if (poll_tick) ticks++;
        end
        n_vec++;
        if (ticks != 3) begin n_err++; $display("FAIL poll_off_ticks: got %0d want 3", ticks); end
        pad_n = 8'($urandom);
        poll_en = 1'b1;
        for (int i = 0; i < 2100 && !latch; i++) step();
        poll_en = 1'b0;
        wait_valid(100, seen);
        n_vec++;
        if (!seen || fd() != VALID_D || buttons !== m_buttons) begin
            n_err++;
            $display("FAIL poll_drop_midframe: got seen=%0d offset=%0d buttons=%h want 1/%0d/%h", seen, fd(), buttons, VALID_D, m_buttons);
        end
        poll_en = 1'b1;
    endtask

    task automatic test_reset_midframe();
        bit seen;
        int early;
        pad_n = ~8'h5A;
        wait_valid(2100, seen);
        n_vec++;
        if (!seen || buttons !== 8'h5A) begin
            n_err++;
            $display("FAIL pre_reset_buttons: got %h want 5a", buttons);
        end
        for (int i = 0; i < 2100 && fd() != 30; i++) step();
        n_vec++;
        if (pulse !== 1'b1) begin n_err++; $display("FAIL pulse3_high: got %b want 1", pulse); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({latch, pulse, valid, busy, buttons} !== 12'h0) begin
            n_err++;
            $display("FAIL midframe_reset: got %b want 0", {latch, pulse, valid, busy, buttons});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        fs = -1;
        m_buttons = 8'h00;
        m_pressed = 8'h00;
        early = 0;
        for (int i = 0; i < 2067; i++) begin
            step();
            if (valid) early++;
        end
        n_vec++;
        if (early != 0) begin n_err++; $display("FAIL early_valid: got %0d want 0", early); end
        step();
        n_vec++;
        if (valid !== 1'b1 || buttons !== m_buttons) begin
            n_err++;
            $display("FAIL post_reset_frame: got valid=%b buttons=%h want 1/%h", valid, buttons, m_buttons);
        end
    endtask

`ifdef NES_PAD_EDGE_EN
    task automatic test_edge();
        logic [7:0] pats [3];
        logic [7:0] want [3];
        bit         seen;
        pats = '{8'h00, 8'h81, 8'h83};
        want = '{8'h00, 8'h81, 8'h02};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            seen = 1'b0;
            pad_n = ~pats[f];
            for (int i = 0; i < 2200 && !seen; i++) begin
                step();
                n_vec++;
                if (pressed !== m_pressed) begin
                    n_err++;
                    $display("FAIL pressed cycle %0d: got %h want %h", cyc, pressed, m_pressed);
                end
                if (valid) begin
                    seen = 1'b1;
                    n_vec++;
                    if (pressed !== want[f]) begin
                        n_err++;
                        $display("FAIL pressed_frame %0d: got %h want %h", f, pressed, want[f]);
                    end
                end
            end
            if (!seen) begin
                n_vec++;
                n_err++;
                $display("FAIL edge_timeout frame %0d: got no valid want valid", f);
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_timing();
        test_pattern();
        test_random();
        test_poll_disable();
        test_reset_midframe();
`ifdef NES_PAD_EDGE_EN
        test_edge();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nes_pad_sequencer.md
Name: nes_pad_sequencer

Overview:
- Owns the NES gamepad serial port and runs one complete read frame per poll period: latch pulse, then 7 clock pulses, sampling the 8 serial button bits.
- Presents a registered, active-high 8-bit button vector with a one-cycle valid strobe to game logic.
- Replaces the ad-hoc latch/pulse generation in the input path; sits between the controller connector pins and the game-state logic.

Parameters:
- POLL_DIV, 666666, clk cycles per poll period (40 MHz / 60 Hz).
- LATCH_CYC, 480, cycles latch is held high (12 us at 40 MHz).
- PULSE_HALF, 240, cycles per pulse high phase and per low phase (6 us).

Ports:
- clk  in  1  system clock, 40 MHz
- reset  in  1  asynchronous, active-low reset
- poll_en  in  1  1 = start a frame on each poll tick; 0 = start no new frames
- pad_data_n  in  1  serial data from the pad, asynchronous, active-low (0 = pressed)
- latch  out  1  pad latch, active-high
- pulse  out  1  pad clock, active-high
- poll_tick  out  1  one-cycle strobe every POLL_DIV cycles
- buttons  out  8  active-high; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- valid  out  1  one-cycle strobe when buttons updates
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous on the falling edge of reset. While reset is low: all outputs 0, counters 0, sync flops 1, state IDLE. A reset asserted mid-frame aborts the frame; buttons keeps no partial data.
- Synchroniser: pad_data_n passes through 2 flops, both reset to 1. Every sample uses the synchronised value.
- Poll counter: free-running, counts 0..POLL_DIV-1 and wraps. poll_tick is high in the cycle the counter equals POLL_DIV-1. The counter is independent of poll_en and of the frame FSM.
- FSM states:
  - IDLE
    - Enters LATCH on the cycle after poll_tick, only if poll_en=1 at the tick.
    - A tick arriving while not in IDLE is dropped, with no queuing.
  - LATCH
    - latch=1 for exactly LATCH_CYC cycles, then goes to LATCH_LO.
  - LATCH_LO
    - latch=0 and pulse=0 for PULSE_HALF cycles.
    - In the last cycle, samples the sync data into shift bit 0 and sets idx=1.
    - Then goes to PULSE_HI.
  - PULSE_HI
    - pulse=1 for PULSE_HALF cycles, then goes to PULSE_LO.
  - PULSE_LO
    - pulse=0 for PULSE_HALF cycles.
    - In the last cycle, samples the sync data into shift bit idx.
    - If idx==7, goes to DONE; otherwise idx increments and the FSM returns to PULSE_HI.
  - DONE
    - One cycle. buttons <= ~shift (inverted to active-high) and valid=1.
    - Then goes to IDLE.
- Exactly 7 pulses per frame.
- Frame timing: with tick at cycle T, latch is high on cycles T+1..T+LATCH_CYC, and valid is high on cycle T+LATCH_CYC+15*PULSE_HALF+1.
- latch, pulse and valid are registered outputs, glitch-free, and decoded from the next-state.
- poll_en falling mid-frame: the frame completes normally. poll_en affects only frame start.
- buttons holds its value between frames. It is 0 after reset until the first DONE.
- Phase counter is sized for max(LATCH_CYC, PULSE_HALF); the poll counter is $clog2(POLL_DIV) bits.

Optional Feature:
- Macro: NES_PAD_EDGE_EN
- Defined:
  - Adds output port pressed [7:0].
  - In the DONE cycle, pressed = new_buttons & ~buttons (newly pressed since the previous frame); 0 in all other cycles.
  - pressed resets to 0. The first frame after reset compares against 0.
- Undefined: the pressed port and its logic are absent. All other behaviour is identical.

Test Plan:
- Test parameters are POLL_DIV=2000, LATCH_CYC=8, PULSE_HALF=4.
- Reset release, poll_en=1, pad model holding all bits 1 (none pressed):
  - poll_tick at cycle 1999.
  - latch high on cycles 2000..2007.
  - 7 pulses of 4 high / 4 low.
  - valid on cycle 2068 with buttons=8'h00.
- Pad model shifting A and Start pressed (serial 0,1,1,0,1,1,1,1), advancing on each pulse rising edge:
  - buttons=8'h09 at valid.
  - Next frame all released: buttons=8'h00.
- Count edges in one frame: exactly 1 latch pulse and 7 pulse rising edges; latch and pulse never high together; busy high for 69 cycles.
- poll_en=0 over 3 ticks: no latch, no valid, buttons unchanged. poll_en dropped mid-frame: the frame still completes with valid.
- reset low during PULSE_HI of pulse 3: latch, pulse, valid and buttons go to 0 immediately. After release there is no valid until the next tick plus 69 cycles.
- NES_PAD_EDGE_EN:
  - Frames with buttons 00 -> 81 -> 83 give pressed 81, then 02.
  - pressed is 0 on all non-valid cycles.
